// File: rtl/score_keeper_if.sv
// Line-clear event handshake between game logic and the score keeper.
//   clr_valid : event valid (game logic -> score keeper)
//   clr_lines : lines cleared by the event, legal 1..4
//   clr_ready : score keeper can accept an event
interface score_keeper_if;
    logic       clr_valid;
    logic [2:0] clr_lines;
    logic       clr_ready;

    modport master (
        output clr_valid,
        output clr_lines,
        input  clr_ready
    );

    modport slave (
        input  clr_valid,
        input  clr_lines,
        output clr_ready
    );
endinterface

// File: rtl/score_keeper.sv
// Tetris score / level / lines bookkeeping.
// Points for an event are base(lines) * (level+1), built by level+1 saturating adds.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   new_game : synchronous clear, wins over any event in flight
//   clr      : line-clear event handshake (slave side)
//   score    : current score, saturating, feeds the display driver
//   level    : current level, 0..MAX_LEVEL
//   lines    : total lines cleared, saturating
module score_keeper #(
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned LEVEL_LINES = 10,
    parameter int unsigned MAX_LEVEL   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    score_keeper_if.slave      clr,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] lines
);

    // Wide enough for lines_in_level + 4 without overflow.
    localparam int unsigned LilW = $clog2(LEVEL_LINES + 4);
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    typedef enum logic [1:0] {StIdle, StAccum, StLvlUpd} state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] lines_q, lines_d;
    logic [3:0]         level_q, level_d;
    logic [LilW-1:0]    lil_q, lil_d;
    logic [10:0]        base_q, base_d;
    logic [2:0]         nlines_q, nlines_d;
    logic [3:0]         cnt_q, cnt_d;

    logic [10:0]        base_lut;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W:0]   lines_sum;
    logic [LilW-1:0]    lil_sum;

    // A zero base marks an illegal line count; such events are consumed and dropped.
    always_comb begin
        base_lut = 11'd0;
        unique case (clr.clr_lines)
            3'd1:    base_lut = 11'd40;
            3'd2:    base_lut = 11'd100;
            3'd3:    base_lut = 11'd300;
            3'd4:    base_lut = 11'd1200;
            default: base_lut = 11'd0;
        endcase
    end

    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(base_q);
    assign lines_sum = {1'b0, lines_q} + (SCORE_W+1)'(nlines_q);
    assign lil_sum   = lil_q + LilW'(nlines_q);

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        lines_d  = lines_q;
        level_d  = level_q;
        lil_d    = lil_q;
        base_d   = base_q;
        nlines_d = nlines_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (clr.clr_valid && (base_lut != 11'd0)) begin
                    base_d   = base_lut;
                    nlines_d = clr.clr_lines;
                    cnt_d    = level_q;
                    state_d  = StAccum;
                end
            end
            StAccum: begin
                score_d = score_sum[SCORE_W] ? ScoreMax : score_sum[SCORE_W-1:0];
                if (cnt_q == 4'd0) begin
                    state_d = StLvlUpd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StLvlUpd: begin
                lines_d = lines_sum[SCORE_W] ? ScoreMax : lines_sum[SCORE_W-1:0];
                if (lil_sum >= LilW'(LEVEL_LINES)) begin
                    lil_d = lil_sum - LilW'(LEVEL_LINES);
                    if (level_q < 4'(MAX_LEVEL)) begin
                        level_d = level_q + 4'd1;
                    end
                end else begin
                    lil_d = lil_sum;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // new_game overrides everything, including a concurrent accept.
        if (new_game) begin
            state_d = StIdle;
            score_d = '0;
            lines_d = '0;
            level_d = '0;
            lil_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            score_q  <= '0;
            lines_q  <= '0;
            level_q  <= '0;
            lil_q    <= '0;
            base_q   <= '0;
            nlines_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            lines_q  <= lines_d;
            level_q  <= level_d;
            lil_q    <= lil_d;
            base_q   <= base_d;
            nlines_q <= nlines_d;
            cnt_q    <= cnt_d;
        end
    end

    assign clr.clr_ready = (state_q == StIdle);
    assign score         = score_q;
    assign level         = level_q;
    assign lines         = lines_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic [15:0] score;
    logic [3:0]  level;
    logic [15:0] lines;

    score_keeper_if clr_if ();

    score_keeper #(
        .SCORE_W    (16),
        .LEVEL_LINES(10),
        .MAX_LEVEL  (9)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .new_game(new_game),
        .clr     (clr_if),
        .score   (score),
        .level   (level),
        .lines   (lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: an accepted event is described by its start score, base,
    // multiplier level and elapsed cycles; outputs follow from plain arithmetic.
    int m_score = 0, m_level = 0, m_lines = 0, m_lil = 0;
    bit m_busy = 0;
    int m_k, m_s0, m_base, m_lvl, m_nl;

    function automatic int base_of(input int n);
        case (n)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return 1200;
            default: return 0;
        endcase
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || new_game) begin
            m_score = 0; m_level = 0; m_lines = 0; m_lil = 0; m_busy = 0;
        end else if (m_busy) begin
            m_k++;
            if (m_k <= m_lvl + 1) begin
                m_score = sat16(m_s0 + m_k * m_base);
            end else begin
                m_lines = sat16(m_lines + m_nl);
                m_lil   = m_lil + m_nl;
                if (m_lil >= 10) begin
                    m_lil -= 10;
                    if (m_level < 9) m_level++;
                end
                m_busy = 0;
            end
        end else if (clr_if.clr_valid && base_of(int'(clr_if.clr_lines)) != 0) begin
            m_busy = 1;
            m_k    = 0;
            m_s0   = m_score;
            m_base = base_of(int'(clr_if.clr_lines));
            m_lvl  = m_level;
            m_nl   = int'(clr_if.clr_lines);
        end
    end

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_score", int'(score), m_score);
            check("cmp_level", int'(level), m_level);
            check("cmp_lines", int'(lines), m_lines);
            check("cmp_ready", int'(clr_if.clr_ready), m_busy ? 0 : 1);
        end
    end

    // Issue one event from a falling edge; returns the number of falling edges ready stayed low.
    task automatic send(input logic [2:0] n, output int low);
        int guard = 0;
        while (!clr_if.clr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!clr_if.clr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait_ready: got 0, expected 1 at %0t", $time);
        end
        clr_if.clr_valid = 1'b1;
        clr_if.clr_lines = n;
        @(negedge clk);
        clr_if.clr_valid = 1'b0;
        low = 0;
        while (!clr_if.clr_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        rst_n = 1'b0;
        new_game = 1'b0;
        clr_if.clr_valid = 1'b0;
        clr_if.clr_lines = 3'd0;
        #12 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level), 0);
        check("rst_lines", int'(lines), 0);
        check("rst_ready", int'(clr_if.clr_ready), 1);

        // Single line at level 0, cycle by cycle
        clr_if.clr_valid = 1'b1;
        clr_if.clr_lines = 3'd1;
        @(posedge clk); #1;
        check("t1_ready_T", int'(clr_if.clr_ready), 0);
        check("t1_score_T", int'(score), 0);
        @(negedge clk);
        clr_if.clr_valid = 1'b0;
        @(posedge clk); #1;
        check("t1_score_T1", int'(score), 40);
        check("t1_lines_T1", int'(lines), 0);
        check("t1_ready_T1", int'(clr_if.clr_ready), 0);
        @(posedge clk); #1;
        check("t1_lines_T2", int'(lines), 1);
        check("t1_ready_T2", int'(clr_if.clr_ready), 1);
        @(negedge clk);

        // Climb to level 2, then a tetris at level 2
        for (int i = 0; i < 19; i++) send(3'd1, low);
        check("t2_score", int'(score), 1200);
        check("t2_level", int'(level), 2);
        check("t2_lines", int'(lines), 20);
        send(3'd4, low);
        check("t2_tetris_low", low, 4);
        check("t2_tetris_score", int'(score), 4800);
        check("t2_tetris_lines", int'(lines), 24);

        // Level boundary: lines_in_level 9 + 2 -> level up, remainder 1
        for (int i = 0; i < 5; i++) send(3'd1, low);
        check("t3_score9", int'(score), 5400);
        check("t3_level9", int'(level), 2);
        send(3'd2, low);
        check("t3_score", int'(score), 5700);
        check("t3_level", int'(level), 3);
        check("t3_lines", int'(lines), 31);

        // Tetrises up to and past MAX_LEVEL, score clamps
        for (int i = 0; i < 30; i++) send(3'd4, low);
        check("t4_level", int'(level), 9);
        check("t4_score", int'(score), 65535);
        check("t4_lines", int'(lines), 151);
        send(3'd1, low);
        check("t4_low", low, 11);
        check("t4_score_hold", int'(score), 65535);
        check("t4_lines2", int'(lines), 152);
        check("t4_level_hold", int'(level), 9);

        // Illegal line counts are consumed without effect
        clr_if.clr_valid = 1'b1;
        clr_if.clr_lines = 3'd0;
        @(posedge clk); #1;
        check("t6_ready_0", int'(clr_if.clr_ready), 1);
        check("t6_lines_0", int'(lines), 152);
        @(negedge clk);
        clr_if.clr_lines = 3'd5;
        @(posedge clk); #1;
        check("t6_ready_5", int'(clr_if.clr_ready), 1);
        check("t6_score_5", int'(score), 65535);
        @(negedge clk);
        clr_if.clr_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of accumulation
        clr_if.clr_valid = 1'b1;
        clr_if.clr_lines = 3'd4;
        @(negedge clk);
        clr_if.clr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("t7_busy", int'(clr_if.clr_ready), 0);
        rst_n = 1'b0;
        #1;
        check("t7_score", int'(score), 0);
        check("t7_level", int'(level), 0);
        check("t7_lines", int'(lines), 0);
        check("t7_ready", int'(clr_if.clr_ready), 1);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);

        // new_game during ACCUM with valid held high
        send(3'd1, low);
        send(3'd1, low);
        check("t5_pre_score", int'(score), 80);
        clr_if.clr_valid = 1'b1;
        clr_if.clr_lines = 3'd4;
        @(negedge clk);
        new_game = 1'b1;
        clr_if.clr_lines = 3'd1;
        @(posedge clk); #1;
        check("t5_score", int'(score), 0);
        check("t5_lines", int'(lines), 0);
        check("t5_level", int'(level), 0);
        check("t5_ready", int'(clr_if.clr_ready), 1);
        @(negedge clk);
        // new_game in IDLE with valid high: not accepted
        clr_if.clr_lines = 3'd2;
        @(posedge clk); #1;
        check("t5_idle_ready", int'(clr_if.clr_ready), 1);
        @(negedge clk);
        new_game = 1'b0;
        clr_if.clr_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_after_score", int'(score), 0);
        check("t5_after_ready", int'(clr_if.clr_ready), 1);
        @(negedge clk);
        send(3'd2, low);
        check("t5_next_score", int'(score), 100);
        check("t5_next_lines", int'(lines), 2);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
